apb_cmd_master: RTL

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_master_pkg.sv | 17 +
 rtl/apb_wait_timer.sv | 33 +++
 rtl/apb_cmd_master.sv | 136 +++++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB command master: FSM states, the address
// alignment mask and the default PREADY wait limit.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Any address bit set under this mask makes a 32-bit access misaligned.
    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for PREADY; expired flags the final
// allowed wait cycle so the master can abort in that same cycle.
module apb_wait_timer
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic RegClk,
    input  logic RegReset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Wait counter: cleared per transfer, saturating so it can never wrap.
    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count >= LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: turns a valid/ready command into one APB
// transfer and returns a held response with error and timeout status.
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  RegClk,
    input  logic                  RegReset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]           PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [31:0]           PRDATA
);

    state_t state;
    state_t next_state;
    logic   go_setup;
    logic   go_misalign;
    logic   done_ready;
    logic   done_timeout;
    logic   expired;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .RegClk  (RegClk),
        .RegReset(RegReset),
        .clear   (go_setup),
        .enable  ((state == ACCESS) && !PREADY),
        .expired (expired)
    );

    // State register; reset drops any transfer in flight without a response.
    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; PREADY is tested before expiry so it wins the last cycle.
    always_comb begin
        next_state   = state;
        go_setup     = 1'b0;
        go_misalign  = 1'b0;
        done_ready   = 1'b0;
        done_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if ((req_addr[1:0] & MISALIGN_MASK) != 2'b00) begin
                        next_state  = RESP;
                        go_misalign = 1'b1;
                    end else begin
                        next_state = SETUP;
                        go_setup   = 1'b1;
                    end
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    next_state = RESP;
                    done_ready = 1'b1;
                end else if (expired) begin
                    next_state   = RESP;
                    done_timeout = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // APB address/data and response fields; each only changes on its load event.
    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            if (go_setup) begin
                PADDR  <= req_addr;
                PWDATA <= req_wdata;
                PWRITE <= req_write;
            end
            if (go_misalign) begin
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b0;
                rsp_rdata   <= '0;
            end else if (done_ready) begin
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
                rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : 32'h0;
            end else if (done_timeout) begin
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_rdata   <= '0;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

endmodule
